// File: rtl/mac_sequencer_if.sv
// Operand stream, result stream and status for the dot-product sequencer.
// The master side is the operand source / result consumer.
interface mac_sequencer_if #(
    parameter int WIDTH = 9
);
    logic                    start;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] result;
    logic                    busy;

    modport master (
        output start, in_valid, x, y, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  start, in_valid, x, y, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mac_sequencer.sv
// Fixed-length signed dot-product sequencer: start, LEN accepted (x,y) beats,
// then hold acc on the result port until the consumer takes it.
module mac_sequencer #(
    parameter int WIDTH = 9,
    parameter int LEN   = 4
) (
    input  logic            system1000,
    input  logic            system1000_rstn,
    mac_sequencer_if.slave  bus
);
    localparam int             CW   = $clog2(LEN + 1);
    localparam logic [CW-1:0]  LAST = CW'(LEN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state, state_nx;
    logic signed [WIDTH-1:0] acc, acc_nx;
    logic signed [WIDTH-1:0] res_q, res_nx;
    logic [CW-1:0]           cnt, cnt_nx;
    logic signed [WIDTH-1:0] prod, sum;

    // Both product and sum wrap to WIDTH bits, matching the MAC stage.
    assign prod = bus.x * bus.y;
    assign sum  = acc + prod;

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            res_q <= '0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            res_q <= res_nx;
        end
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        res_nx   = res_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = ACCUM;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                end
            end
            ACCUM: begin
                // in_ready is a pure state decode, so in_valid alone marks a beat here
                if (bus.in_valid) begin
                    acc_nx = sum;
                    cnt_nx = cnt + 1'b1;
                    if (cnt == LAST) begin
                        res_nx   = sum;
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = res_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: LEN=4 and LEN=1 instances checked every
// cycle against a transaction-level dot-product model plus literal results.
module tb_mac_sequencer;
    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    mac_sequencer_if #(.WIDTH(9)) ia ();
    mac_sequencer_if #(.WIDTH(9)) ib ();

    mac_sequencer #(.WIDTH(9), .LEN(4)) u_a (
        .system1000(clk), .system1000_rstn(rstn), .bus(ia));
    mac_sequencer #(.WIDTH(9), .LEN(1)) u_b (
        .system1000(clk), .system1000_rstn(rstn), .bus(ib));

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a run collects LEN products as plain integers; the result is the
    // full-precision sum reduced to 9-bit two's complement.
    int lens[2]    = '{4, 1};
    int m_phase[2] = '{0, 0};  // 0 idle, 1 collecting pairs, 2 result offered
    int m_cnt[2]   = '{0, 0};
    int m_sum[2]   = '{0, 0};
    int m_res[2]   = '{0, 0};

    function automatic int wrap9(input int v);
        logic [8:0] t;
        t = v[8:0];
        return int'($signed(t));
    endfunction

    task automatic model_step(input int d, input logic st, input logic v,
                              input logic signed [8:0] x, input logic signed [8:0] y,
                              input logic ordy);
        case (m_phase[d])
            0: if (st) begin m_phase[d] = 1; m_cnt[d] = 0; m_sum[d] = 0; end
            1: if (v) begin
                m_sum[d] += int'(x) * int'(y);
                m_cnt[d]++;
                if (m_cnt[d] == lens[d]) begin
                    m_res[d]   = wrap9(m_sum[d]);
                    m_phase[d] = 2;
                end
            end
            default: if (ordy) m_phase[d] = 0;
        endcase
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int d = 0; d < 2; d++) begin
                m_phase[d] = 0; m_cnt[d] = 0; m_sum[d] = 0; m_res[d] = 0;
            end
        end else begin
            model_step(0, ia.start, ia.in_valid, ia.x, ia.y, ia.out_ready);
            model_step(1, ib.start, ib.in_valid, ib.x, ib.y, ib.out_ready);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_in_ready",  int'(ia.in_ready),  int'(m_phase[0] == 1));
            chk("a_out_valid", int'(ia.out_valid), int'(m_phase[0] == 2));
            chk("a_busy",      int'(ia.busy),      int'(m_phase[0] != 0));
            chk("a_result",    int'(ia.result),    m_res[0]);
            chk("b_in_ready",  int'(ib.in_ready),  int'(m_phase[1] == 1));
            chk("b_out_valid", int'(ib.out_valid), int'(m_phase[1] == 2));
            chk("b_busy",      int'(ib.busy),      int'(m_phase[1] != 0));
            chk("b_result",    int'(ib.result),    m_res[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int bx[4] = '{1, 3, -2, 0};
    int by[4] = '{2, 4, 5, 7};
    int wx[4] = '{15, 15, 0, 0};
    int vx[4] = '{16, 0, 0, 0};

    // Full LEN=4 run. hold: cycles of out_ready=0 in DONE (start pulsed inside).
    // hs_start: start raised together with the releasing out_ready.
    task automatic run_a(input int px[4], input int py[4], input int gap,
                         input int hold, input bit hs_start,
                         output int res, output int cycles);
        chk("pre_busy", int'(ia.busy), 0);
        ia.out_ready = (hold == 0);
        ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        cycles = 1;
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < gap; b++) begin
                ia.in_valid = 1'b0;
                tick();
                cycles++;
            end
            ia.in_valid = 1'b1;
            ia.x = 9'(px[k]);
            ia.y = 9'(py[k]);
            tick();
            cycles++;
        end
        ia.in_valid = 1'b0;
        chk("done_out_valid", int'(ia.out_valid), 1);
        res = int'(ia.result);
        for (int h = 0; h < hold; h++) begin
            chk("hold_out_valid", int'(ia.out_valid), 1);
            chk("hold_in_ready",  int'(ia.in_ready), 0);
            chk("hold_result",    int'(ia.result), res);
            ia.start = (h == 2);
            tick();
            cycles++;
        end
        ia.start = hs_start;
        ia.out_ready = 1'b1;
        tick();
        cycles++;
        chk("post_hs_busy",      int'(ia.busy), 0);
        chk("post_hs_out_valid", int'(ia.out_valid), 0);
    endtask

    int res, cyc;

    initial begin
        ia.start = 0; ia.in_valid = 0; ia.x = 0; ia.y = 0; ia.out_ready = 1;
        ib.start = 0; ib.in_valid = 0; ib.x = 0; ib.y = 0; ib.out_ready = 1;
        #2 rstn = 1'b0;
        #1;
        chk("rst_in_ready",  int'(ia.in_ready), 0);
        chk("rst_out_valid", int'(ia.out_valid), 0);
        chk("rst_busy",      int'(ia.busy), 0);
        chk("rst_result",    int'(ia.result), 0);
        chk_en = 1'b1;
        tick();
        rstn = 1'b1;
        tick();

        run_a(bx, by, 0, 0, 1'b0, res, cyc);
        chk("basic_result", res, 4);
        chk("basic_cycles", cyc, 6);

        run_a(wx, wx, 0, 0, 1'b0, res, cyc);
        chk("wrap_result", res, -62);
        run_a(vx, vx, 0, 0, 1'b0, res, cyc);
        chk("wrap256_result", res, -256);

        run_a(bx, by, 3, 0, 1'b0, res, cyc);
        chk("bubble_result", res, 4);
        chk("bubble_cycles", cyc, 18);

        // Backpressure with an ignored start, then a start held through the handshake.
        run_a(bx, by, 0, 5, 1'b1, res, cyc);
        chk("bp_result", res, 4);
        chk("bp_cycles", cyc, 11);
        tick();
        ia.start = 1'b0;
        chk("late_start_in_ready", int'(ia.in_ready), 1);

        // Two beats accepted, then reset mid-run.
        for (int k = 0; k < 2; k++) begin
            ia.in_valid = 1'b1;
            ia.x = 9'(bx[k]);
            ia.y = 9'(by[k]);
            tick();
        end
        ia.in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("midrst_in_ready", int'(ia.in_ready), 0);
        chk("midrst_busy",     int'(ia.busy), 0);
        chk("midrst_result",   int'(ia.result), 0);
        tick();
        rstn = 1'b1;
        tick();
        run_a(bx, by, 0, 0, 1'b0, res, cyc);
        chk("after_rst_result", res, 4);

        // LEN=1 instance: the single beat goes straight to DONE.
        ib.start = 1'b1;
        tick();
        ib.start = 1'b0;
        chk("len1_in_ready", int'(ib.in_ready), 1);
        ib.in_valid = 1'b1;
        ib.x = -9'sd3;
        ib.y = 9'sd7;
        tick();
        ib.in_valid = 1'b0;
        chk("len1_out_valid", int'(ib.out_valid), 1);
        chk("len1_result",    int'(ib.result), -21);
        tick();
        chk("len1_busy", int'(ib.busy), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
